water_inlet_arbiter: RTL and testbench
======================================

WATER_INLET_ARBITER -- requirements
Module: water_inlet_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of washer controllers sharing one water inlet.
REQ-002 The block SHALL have parameter MAX_HOLD, default 10, giving the maximum grant length in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: bit i set means controller i requests the inlet.
REQ-006 The block SHALL have port rel, input, NREQ bits: bit i is controller i's one-cycle release pulse.
REQ-007 The block SHALL have port stop, input, 1 bit: synchronous abort of the current grant.
REQ-008 The block SHALL have port grant, output reg, NREQ bits: one-hot or zero owner of the inlet.
REQ-009 The block SHALL have port valve_on, output reg, 1 bit: shared inlet valve drive.
REQ-010 The block SHALL have port busy, output reg, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port timeout, output reg, NREQ bits: one-cycle pulse on the bit of a force-released owner.

Function
REQ-012 The block SHALL implement the states IDLE, GRANT and GAP.
REQ-013 In IDLE with req nonzero, the block SHALL pick the winner round-robin, searching upward from last_owner+1 with wrap from NREQ-1 to 0, and enter GRANT.
REQ-014 Grant latency SHALL be exactly 1 cycle: req sampled at edge N gives grant one-hot and valve_on=1 after edge N.
REQ-015 In GRANT the block SHALL hold grant constant and increment hold_cnt, cleared on entry, by 1 per cycle.
REQ-016 GRANT SHALL exit to GAP when rel[owner]=1 or req[owner]=0, and grant and valve_on SHALL be 0 after that edge.
REQ-017 rel or req changes on non-owner bits SHALL be ignored during GRANT and GAP.
REQ-018 GAP SHALL last exactly 1 cycle with grant=0 and valve_on=0, then enter IDLE; arbitration SHALL NOT occur in GAP.
REQ-019 last_owner SHALL update on every grant issue; after reset it SHALL be NREQ-1, so requester 0 wins first.
REQ-020 When stop=1 the block SHALL go to IDLE with grant=0 and valve_on=0 after that edge, SHALL NOT pulse timeout, and SHALL take priority over all other events.
REQ-021 When stop is held, IDLE SHALL NOT arbitrate.
REQ-022 When rel and timeout fall due in the same cycle, rel SHALL win and timeout SHALL NOT pulse.
REQ-023 grant SHALL never have more than one bit set; valve_on SHALL equal the OR of grant in every cycle.
REQ-024 hold_cnt SHALL be wide enough for MAX_HOLD and SHALL NOT wrap.

Reset
REQ-025 While reset=0 the block SHALL set state=IDLE, grant=0, valve_on=0, busy=0, timeout=0, hold_cnt=0 and last_owner=NREQ-1 immediately, independent of clk.
REQ-026 Reset asserted mid-GRANT SHALL drop valve_on without waiting for a clock edge.
REQ-027 After reset deasserts, the first arbitration SHALL occur at the first clk edge with req nonzero.

Configuration
REQ-028 The feature macro SHALL be WATER_ARB_TIMEOUT_EN.
REQ-029 With WATER_ARB_TIMEOUT_EN defined, GRANT SHALL force-release to GAP when hold_cnt reaches MAX_HOLD-1 with no rel; timeout[owner] SHALL pulse 1 cycle coincident with the first GAP cycle, so the owner holds the grant for exactly MAX_HOLD cycles.
REQ-030 Without WATER_ARB_TIMEOUT_EN, grants SHALL last until rel, req drop or stop; timeout SHALL be tied to 0.

Verification
REQ-031 After reset, req=4'b0101 held -> grant=0001 for 1+ cycles, rel[0] pulse, 1 GAP cycle, then grant=0100.
REQ-032 req=4'b1111 held, each owner pulses rel after 3 cycles -> grant order 0001,0010,0100,1000,0001, with 1 GAP cycle of valve_on=0 between grants.
REQ-033 With WATER_ARB_TIMEOUT_EN, req=4'b0010 held with no rel -> grant=0010 for exactly 10 cycles, timeout=0010 for 1 cycle, then after GAP regrant to 0010.
REQ-034 stop=1 mid-grant with req=4'b0001 -> grant=0 next edge, timeout=0, no regrant until stop=0.
REQ-035 reset=0 asynchronously mid-GRANT -> valve_on=0 before next edge; after release, req=4'b1000 -> grant=1000 one cycle later.
REQ-036 rel[owner] in the same cycle as the hold limit -> GAP entered, timeout stays 0.

Source files
------------

// File: rtl/water_inlet_arbiter_if.sv
// Handshake bundle between the washer controllers (master) and the water inlet arbiter (slave).
interface water_inlet_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic            stop;
    logic [NREQ-1:0] grant;
    logic            valve_on;
    logic            busy;
    logic [NREQ-1:0] timeout;

    modport master (
        output req, rel, stop,
        input  grant, valve_on, busy, timeout
    );

    modport slave (
        input  req, rel, stop,
        output grant, valve_on, busy, timeout
    );
endinterface

// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter sharing one water inlet valve among NREQ washer controllers.
// Optional hold-limit force release is enabled by defining WATER_ARB_TIMEOUT_EN.
module water_inlet_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 10
) (
    input logic                  clk,
    input logic                  reset,
    water_inlet_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_TOP  = CW'(MAX_HOLD);
`ifdef WATER_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
`endif

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] timeout_q, timeout_d;
    logic            valve_q, busy_q;
    logic [CW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   winner;
    logic            found;

    // Search upward from the previous owner so every requester is served in turn.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && bus.req[(int'(last_q) + i) % NREQ]) begin
                found  = 1'b1;
                winner = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        timeout_d = '0;
        hold_d    = hold_q;
        last_d    = last_q;
        if (bus.stop) begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_d = GRANT;
                        grant_d = NREQ'(1) << winner;
                        hold_d  = '0;
                        last_d  = winner;
                    end
                end
                GRANT: begin
                    // last_q always names the current owner while in GRANT.
                    if (bus.rel[last_q] || !bus.req[last_q]) begin
                        state_d = GAP;
                        grant_d = '0;
                    end
`ifdef WATER_ARB_TIMEOUT_EN
                    else if (hold_q == HOLD_LAST) begin
                        state_d   = GAP;
                        grant_d   = '0;
                        timeout_d = grant_q;
                    end
`endif
                    else if (hold_q != HOLD_TOP) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valve_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= '0;
            hold_q    <= '0;
            last_q    <= IW'(NREQ - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valve_q   <= |grant_d;
            busy_q    <= (state_d != IDLE);
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.valve_on = valve_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Self-checking bench for water_inlet_arbiter: directed scenarios plus a per-cycle reference model.
module tb_water_inlet_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 10;
`ifdef WATER_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    water_inlet_arbiter_if #(.NREQ(NREQ)) bus ();

    water_inlet_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), gap flag, cycles held so far.
    int              m_owner = -1;
    bit              m_gap   = 1'b0;
    int              m_held  = 0;
    int              m_last  = NREQ - 1;
    logic [NREQ-1:0] m_to    = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_held  = 0;
            m_last  = NREQ - 1;
            m_to    = '0;
        end else begin
            m_to = '0;
            if (bus.stop) begin
                m_owner = -1;
                m_gap   = 1'b0;
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (m_owner < 0 && bus.req[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_held  = 1;
                    end
                end
            end else if (bus.rel[m_owner] || !bus.req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (TO_EN && m_held >= MAX_HOLD) begin
                m_to[m_owner] = 1'b1;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_grant",   bus.grant,    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("cmp_valve",   bus.valve_on, (m_owner >= 0) ? 32'd1 : 32'd0);
            check("cmp_busy",    bus.busy,     (m_owner >= 0 || m_gap) ? 32'd1 : 32'd0);
            check("cmp_timeout", bus.timeout,  m_to);
            check("cmp_onehot",  ($countones(bus.grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset    = 1'b0;
        bus.req  = '0;
        bus.rel  = '0;
        bus.stop = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int n = 0; n < 8; n++) begin
            if (bus.grant != '0) begin
                g = bus.grant;
                return;
            end
            step();
        end
        check("wait_grant_bound", 32'd0, 32'd1);
    endtask

    logic [NREQ-1:0] g;
    logic [NREQ-1:0] order_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int              cnt;

    initial begin
        bus.req  = '0;
        bus.rel  = '0;
        bus.stop = 1'b0;
        #12;
        check("rst_grant",   bus.grant,    0);
        check("rst_valve",   bus.valve_on, 0);
        check("rst_busy",    bus.busy,     0);
        check("rst_timeout", bus.timeout,  0);
        @(negedge clk);
        #2;
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Two requesters, owner 0 releases, non-owner rel ignored.
        bus.req = 4'b0101;
        step();
        check("t1_first", bus.grant, 4'b0001);
        bus.rel = 4'b0100;
        step();
        check("t1_hold", bus.grant, 4'b0001);
        bus.rel = 4'b0001;
        step();
        bus.rel = '0;
        check("t1_gap_grant", bus.grant, 0);
        check("t1_gap_busy",  bus.busy,  1);
        step();
        check("t1_idle_busy", bus.busy, 0);
        step();
        check("t1_second", bus.grant, 4'b0100);
        bus.req = '0;
        step();
        step();

        // All four requesting, each releases after 3 cycles.
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            check($sformatf("t2_order%0d", n), g, order_exp[n]);
            step();
            step();
            bus.rel = g;
            step();
            bus.rel = '0;
            check($sformatf("t2_gap%0d", n), bus.valve_on, 0);
        end
        bus.req = '0;
        step();
        step();
        step();

        // Single requester holding without release.
        do_reset();
        bus.req = 4'b0010;
        step();
        cnt = 0;
        while (bus.grant == 4'b0010 && cnt < 20) begin
            cnt++;
            step();
        end
`ifdef WATER_ARB_TIMEOUT_EN
        check("t3_hold_len", cnt, MAX_HOLD);
        check("t3_timeout",  bus.timeout, 4'b0010);
        check("t3_gap",      bus.grant, 0);
        step();
        check("t3_to_pulse", bus.timeout, 0);
        step();
        check("t3_regrant",  bus.grant, 4'b0010);
`else
        check("t3_hold_len", cnt, 20);
        check("t3_no_to",    bus.timeout, 0);
        check("t3_still",    bus.grant, 4'b0010);
`endif
        bus.req = '0;
        step();
        step();
        step();

        // Stop aborts the grant and blocks arbitration while held.
        do_reset();
        bus.req = 4'b0001;
        step();
        check("t4_grant", bus.grant, 4'b0001);
        step();
        bus.stop = 1'b1;
        step();
        check("t4_stop_grant",   bus.grant,   0);
        check("t4_stop_timeout", bus.timeout, 0);
        check("t4_stop_busy",    bus.busy,    0);
        step();
        step();
        check("t4_held", bus.grant, 0);
        bus.stop = 1'b0;
        step();
        check("t4_regrant", bus.grant, 4'b0001);
        bus.req = '0;
        step();
        step();

        // Release lands on the same edge as the hold limit.
        do_reset();
        bus.req = 4'b0001;
        step();
        for (int n = 0; n < MAX_HOLD - 1; n++) step();
        check("t5_pre", bus.grant, 4'b0001);
        bus.rel = 4'b0001;
        step();
        bus.rel = '0;
        check("t5_grant",   bus.grant,   0);
        check("t5_timeout", bus.timeout, 0);
        check("t5_busy",    bus.busy,    1);
        bus.req = '0;
        step();
        step();

        // Asynchronous reset in the middle of a grant.
        bus.req = 4'b0100;
        step();
        check("t6_grant", bus.grant, 4'b0100);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valve", bus.valve_on, 0);
        check("t6_async_grant", bus.grant,    0);
        bus.req = '0;
        @(negedge clk);
        #2;
        reset   = 1'b1;
        bus.req = 4'b1000;
        step();
        check("t6_after", bus.grant, 4'b1000);
        bus.req = '0;
        step();
        step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
